// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 receive path.
// Holds the decoder state enum, the 50 MHz strip timing shared with the
// driver, GRB packing order, field widths and the pixel address mapping.
package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2
  } state_e;

  // 50 MHz strip timing used by the driver (and by loopback stimulus)
  localparam int unsigned T_BIT_CYC   = 63;
  localparam int unsigned T0H_CYC     = 21;
  localparam int unsigned T1H_CYC     = 42;
  localparam int unsigned T_RESET_CYC = 2600;

  localparam int unsigned COL_W     = 8;
  localparam int unsigned PIX_W     = 3 * COL_W;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned BIT_IDX_W = 5;
  localparam int unsigned PIX_MAX   = 1023;

  // Wire order on the strip: green first, MSB first
  typedef struct packed {
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] b;
  } grb_t;

  // Pixel index to RAM address, optionally mirrored
  function automatic logic [ADDR_W-1:0] map_addr(input logic [CNT_W-1:0] idx,
                                                 input logic [CNT_W-1:0] last,
                                                 input logic             rev);
    return ADDR_W'(rev ? (last - idx) : idx);
  endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// ws2812_pulse_meter: synchronizes the strip line and measures pulses.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   data_i         raw strip line (asynchronous)
//   din_s          synchronized line level
//   rise_strobe    one cycle after a rising edge of din_s
//   fall_strobe    one cycle after a falling edge of din_s
//   high_len       high length of the pulse that just ended, valid with fall_strobe
//   gap            one-cycle pulse once the line has been low CYCLES_RESET cycles
module ws2812_pulse_meter
  import ws2812_pkg::*;
#(
  parameter int unsigned CYCLES_RESET = 2500
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_i,
  output logic             din_s,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic [LEN_W-1:0] high_len,
  output logic             gap
);

  localparam logic [LEN_W-1:0] CNT_SAT = '1;
  localparam logic [LEN_W-1:0] GAP_AT  = LEN_W'(CYCLES_RESET - 1);

  logic             sync_q;
  logic             din_d;
  logic [LEN_W-1:0] high_cnt;
  logic [LEN_W-1:0] low_cnt;

  // Counters load 1 on the edge so each holds the number of cycles at its level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 1'b0;
      din_s       <= 1'b0;
      din_d       <= 1'b0;
      rise_strobe <= 1'b0;
      fall_strobe <= 1'b0;
      high_len    <= '0;
      gap         <= 1'b0;
      high_cnt    <= '0;
      low_cnt     <= '0;
    end else begin
      sync_q      <= data_i;
      din_s       <= sync_q;
      din_d       <= din_s;
      rise_strobe <= din_s & ~din_d;
      fall_strobe <= ~din_s & din_d;
      high_len    <= high_cnt;
      gap         <= ~din_s & (low_cnt == GAP_AT);

      if (din_s && !din_d) begin
        high_cnt <= LEN_W'(1);
      end else if (din_s && (high_cnt != CNT_SAT)) begin
        high_cnt <= high_cnt + LEN_W'(1);
      end

      if (!din_s && din_d) begin
        low_cnt <= LEN_W'(1);
      end else if (!din_s && (low_cnt != CNT_SAT)) begin
        low_cnt <= low_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 strip decoder writing GRB pixels to an external RAM.
// Ports:
//   clk_i, rst_ni        50 MHz clock, async active-low reset
//   data_i               strip data line (asynchronous)
//   address_o, r/g/b_o   pixel write address and colour, valid with we_o
//   we_o                 one-cycle write strobe
//   frame_done_o         one-cycle pulse on the end-of-frame low gap
//   pixel_count_o        pixels in last frame (saturating), with frame_done_o
//   overflow_o           last frame exceeded LED_COUNT, with frame_done_o
//   error_o              one-cycle pulse on a protocol error
//   data_o               forwards excess pixels when WS2812_RX_PASSTHRU_EN is
//                        defined, constant 0 otherwise
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned LED_COUNT        = 256,
  parameter int unsigned REVERSE          = 0,
  parameter int unsigned CYCLES_MIN_HIGH  = 8,
  parameter int unsigned CYCLES_THRESHOLD = 32,
  parameter int unsigned CYCLES_MAX_HIGH  = 60,
  parameter int unsigned CYCLES_RESET     = 2500
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_i,
  output logic [ADDR_W-1:0] address_o,
  output logic [COL_W-1:0]  r_o,
  output logic [COL_W-1:0]  g_o,
  output logic [COL_W-1:0]  b_o,
  output logic              we_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  pixel_count_o,
  output logic              overflow_o,
  output logic              error_o,
  output logic              data_o
);

`ifdef WS2812_RX_PASSTHRU_EN
  localparam logic PASSTHRU = 1'b1;
`else
  localparam logic PASSTHRU = 1'b0;
`endif

  localparam logic [CNT_W-1:0]     LED_CNT   = CNT_W'(LED_COUNT);
  localparam logic [CNT_W-1:0]     LAST_ADDR = CNT_W'(LED_COUNT - 1);
  localparam logic [CNT_W-1:0]     PIX_SAT   = CNT_W'(PIX_MAX);
  localparam logic [BIT_IDX_W-1:0] BIT_TOP   = BIT_IDX_W'(PIX_W - 1);

  logic             din_s;
  logic             rise_strobe;
  logic             fall_strobe;
  logic [LEN_W-1:0] high_len;
  logic             gap;

  state_e               state;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0]     pix_idx;
  logic                 ovf;
  logic                 pix_pend;
  logic [PIX_W-1:0]     shift_q;
  grb_t                 px;
  logic                 bad_len;
  logic                 bit_val;

  ws2812_pulse_meter #(
    .CYCLES_RESET(CYCLES_RESET)
  ) u_meter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .din_s      (din_s),
    .rise_strobe(rise_strobe),
    .fall_strobe(fall_strobe),
    .high_len   (high_len),
    .gap        (gap)
  );

  assign px      = grb_t'(shift_q);
  assign bad_len = (high_len < LEN_W'(CYCLES_MIN_HIGH)) ||
                   (high_len > LEN_W'(CYCLES_MAX_HIGH));
  assign bit_val = (high_len >= LEN_W'(CYCLES_THRESHOLD));

  // Frame decoder FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= SYNC;
      bit_idx       <= BIT_TOP;
      pix_idx       <= '0;
      ovf           <= 1'b0;
      pix_pend      <= 1'b0;
      shift_q       <= '0;
      address_o     <= '0;
      r_o           <= '0;
      g_o           <= '0;
      b_o           <= '0;
      we_o          <= 1'b0;
      frame_done_o  <= 1'b0;
      pixel_count_o <= '0;
      overflow_o    <= 1'b0;
      error_o       <= 1'b0;
      data_o        <= 1'b0;
    end else begin
      we_o         <= 1'b0;
      frame_done_o <= 1'b0;
      error_o      <= 1'b0;
      pix_pend     <= 1'b0;

      case (state)
        SYNC: begin
          if (gap) state <= IDLE;
        end
        IDLE: begin
          bit_idx <= BIT_TOP;
          pix_idx <= '0;
          ovf     <= 1'b0;
          if (rise_strobe) state <= DATA;
        end
        DATA: begin
          if (gap) begin
            frame_done_o  <= 1'b1;
            pixel_count_o <= pix_idx;
            overflow_o    <= ovf;
            // a partially received pixel is dropped and flagged
            if (bit_idx != BIT_TOP) error_o <= 1'b1;
            state <= IDLE;
          end else if (fall_strobe) begin
            if (bad_len) begin
              error_o <= 1'b1;
              state   <= SYNC;
            end else begin
              shift_q[bit_idx] <= bit_val;
              if (bit_idx == '0) begin
                bit_idx  <= BIT_TOP;
                pix_pend <= 1'b1;
              end else begin
                bit_idx <= bit_idx - BIT_IDX_W'(1);
              end
            end
          end
        end
        default: state <= SYNC;
      endcase

      // Completed pixel: write it if it fits, otherwise just note overflow
      if (pix_pend) begin
        if (pix_idx < LED_CNT) begin
          we_o      <= 1'b1;
          address_o <= map_addr(pix_idx, LAST_ADDR, (REVERSE != 0));
          g_o       <= px.g;
          r_o       <= px.r;
          b_o       <= px.b;
        end else begin
          ovf <= 1'b1;
        end
        if (pix_idx != PIX_SAT) pix_idx <= pix_idx + CNT_W'(1);
      end

      // Excess pixels are forwarded downstream only in the pass-through build
      data_o <= PASSTHRU & (state == DATA) & (pix_idx >= LED_CNT) & din_s;
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed self-checking bench for ws2812_rx.
// Two instances share one stimulus line: u_a with defaults and u_b with
// LED_COUNT=4, REVERSE=1 for the overflow/mirroring scenario.
`timescale 1ns/1ps
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic data;
  logic pt_win;

  always #10 clk = ~clk;

  logic [8:0] a_addr, b_addr;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic       a_we, a_fd, a_ovf, a_err, a_do;
  logic       b_we, b_fd, b_ovf, b_err, b_do;
  logic [9:0] a_cnt, b_cnt;

  ws2812_rx u_a (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .address_o(a_addr),
    .r_o(a_r), .g_o(a_g), .b_o(a_b), .we_o(a_we), .frame_done_o(a_fd),
    .pixel_count_o(a_cnt), .overflow_o(a_ovf), .error_o(a_err), .data_o(a_do)
  );

  ws2812_rx #(.LED_COUNT(4), .REVERSE(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .address_o(b_addr),
    .r_o(b_r), .g_o(b_g), .b_o(b_b), .we_o(b_we), .frame_done_o(b_fd),
    .pixel_count_o(b_cnt), .overflow_o(b_ovf), .error_o(b_err), .data_o(b_do)
  );

  logic [47:0] a_all, b_all;
  assign a_all = {a_addr, a_r, a_g, a_b, a_we, a_fd, a_cnt, a_ovf, a_err, a_do};
  assign b_all = {b_addr, b_r, b_g, b_b, b_we, b_fd, b_cnt, b_ovf, b_err, b_do};

  int checks = 0;
  int passed = 0;

  // Event log filled by the monitor; scenarios compare deltas against it
  int          a_wn = 0, b_wn = 0, a_fdn = 0, a_errn = 0, a_errfd = 0, pt_bad = 0;
  logic [23:0] a_wd [64];
  logic [8:0]  a_wa [64];
  logic [23:0] b_wd [64];
  logic [8:0]  b_wa [64];
  logic [9:0]  a_fcnt = '0, b_fcnt = '0;
  logic        a_fovf = 1'b0, b_fovf = 1'b0;
  logic [2:0]  hist = '0;
  logic        pt_exp;

`ifdef WS2812_RX_PASSTHRU_EN
  assign pt_exp = pt_win ? hist[2] : 1'b0;
`else
  assign pt_exp = 1'b0;
`endif

  always @(posedge clk) hist <= {hist[1:0], data};

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_we) begin
        a_wa[a_wn % 64] <= a_addr;
        a_wd[a_wn % 64] <= {a_g, a_r, a_b};
        a_wn <= a_wn + 1;
      end
      if (b_we) begin
        b_wa[b_wn % 64] <= b_addr;
        b_wd[b_wn % 64] <= {b_g, b_r, b_b};
        b_wn <= b_wn + 1;
      end
      if (a_fd) begin
        a_fdn  <= a_fdn + 1;
        a_fcnt <= a_cnt;
        a_fovf <= a_ovf;
      end
      if (b_fd) begin
        b_fcnt <= b_cnt;
        b_fovf <= b_ovf;
      end
      if (a_err) begin
        a_errn <= a_errn + 1;
        if (a_fd) a_errfd <= a_errfd + 1;
      end
      if ((a_do !== 1'b0) || (b_do !== pt_exp)) pt_bad <= pt_bad + 1;
    end
  end

  task automatic idle_low(input int n);
    data = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int per);
    data = 1'b1;
    repeat (hi) @(negedge clk);
    data = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  // Sends the top nbits of v, MSB first
  task automatic send_bits(input logic [23:0] v, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) begin
      pulse(v[i] ? int'(T1H_CYC) : int'(T0H_CYC), int'(T_BIT_CYC));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_all !== 48'h0) $display("FAIL reset_a: got %h expected 0", a_all);
    else passed++;
    checks++;
    if (b_all !== 48'h0) $display("FAIL reset_b: got %h expected 0", b_all);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel();
    int w0, wb0, f0, e0;
    w0 = a_wn; wb0 = b_wn; f0 = a_fdn; e0 = a_errn;
    idle_low(int'(T_RESET_CYC));
    send_bits(24'hA53C0F, 24);
    idle_low(int'(T_RESET_CYC));
    chk("single_writes", 32'(a_wn - w0), 32'd1);
    chk("single_addr", 32'(a_wa[w0 % 64]), 32'd0);
    chk("single_grb", 32'(a_wd[w0 % 64]), 32'hA53C0F);
    chk("single_rev_writes", 32'(b_wn - wb0), 32'd1);
    chk("single_rev_addr", 32'(b_wa[wb0 % 64]), 32'd3);
    chk("single_frame_done", 32'(a_fdn - f0), 32'd1);
    chk("single_count", 32'(a_fcnt), 32'd1);
    chk("single_ovf", 32'(a_fovf), 32'd0);
    chk("single_err", 32'(a_errn - e0), 32'd0);
  endtask

  task automatic test_glitch();
    int w0, f0, e0;
    w0 = a_wn; f0 = a_fdn; e0 = a_errn;
    pulse(4, 63);
    idle_low(100);
    send_bits(24'hFFFFFF, 24);
    idle_low(int'(T_RESET_CYC));
    send_bits(24'h123456, 24);
    idle_low(int'(T_RESET_CYC));
    chk("glitch_err", 32'(a_errn - e0), 32'd1);
    chk("glitch_writes", 32'(a_wn - w0), 32'd1);
    chk("glitch_addr", 32'(a_wa[w0 % 64]), 32'd0);
    chk("glitch_grb", 32'(a_wd[w0 % 64]), 32'h123456);
    chk("glitch_frame_done", 32'(a_fdn - f0), 32'd1);
    chk("glitch_count", 32'(a_fcnt), 32'd1);
  endtask

  task automatic test_partial();
    int w0, f0, e0, ef0;
    w0 = a_wn; f0 = a_fdn; e0 = a_errn; ef0 = a_errfd;
    send_bits(24'hABCDEF, 12);
    idle_low(int'(T_RESET_CYC));
    chk("partial_writes", 32'(a_wn - w0), 32'd0);
    chk("partial_err", 32'(a_errn - e0), 32'd1);
    chk("partial_frame_done", 32'(a_fdn - f0), 32'd1);
    chk("partial_err_with_fd", 32'(a_errfd - ef0), 32'd1);
    chk("partial_count", 32'(a_fcnt), 32'd0);
  endtask

  task automatic test_long_pulse();
    int w0, f0, e0;
    w0 = a_wn; f0 = a_fdn; e0 = a_errn;
    send_bits(24'hF0F0F0, 5);
    pulse(70, 100);
    send_bits(24'h555555, 18);
    idle_low(int'(T_RESET_CYC));
    send_bits(24'hC0FFEE, 24);
    idle_low(int'(T_RESET_CYC));
    chk("long_err", 32'(a_errn - e0), 32'd1);
    chk("long_frame_done", 32'(a_fdn - f0), 32'd1);
    chk("long_writes", 32'(a_wn - w0), 32'd1);
    chk("long_grb", 32'(a_wd[w0 % 64]), 32'hC0FFEE);
    chk("long_count", 32'(a_fcnt), 32'd1);
  endtask

  task automatic test_overflow();
    logic [23:0] px [5];
    int w0, wb0, p0;
    px[0] = 24'h102030; px[1] = 24'h405060; px[2] = 24'h708090;
    px[3] = 24'hA0B0C0; px[4] = 24'hD0E0F0;
    w0 = a_wn; wb0 = b_wn; p0 = pt_bad;
    for (int i = 0; i < 4; i++) send_bits(px[i], 24);
    pt_win = 1'b1;
    send_bits(px[4], 24);
    idle_low(20);
    pt_win = 1'b0;
    idle_low(int'(T_RESET_CYC));
    chk("ovf_a_writes", 32'(a_wn - w0), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("ovf_a_addr", 32'(a_wa[(w0 + i) % 64]), 32'(i));
      chk("ovf_a_grb", 32'(a_wd[(w0 + i) % 64]), 32'(px[i]));
    end
    chk("ovf_b_writes", 32'(b_wn - wb0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_b_addr", 32'(b_wa[(wb0 + i) % 64]), 32'(3 - i));
      chk("ovf_b_grb", 32'(b_wd[(wb0 + i) % 64]), 32'(px[i]));
    end
    chk("ovf_a_count", 32'(a_fcnt), 32'd5);
    chk("ovf_a_flag", 32'(a_fovf), 32'd0);
    chk("ovf_b_count", 32'(b_fcnt), 32'd5);
    chk("ovf_b_flag", 32'(b_fovf), 32'd1);
    chk("passthru_bad_cycles", 32'(pt_bad - p0), 32'd0);
  endtask

  task automatic test_mid_reset();
    int w0, f0, e0;
    send_bits(24'h00FF00, 10);
    data = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_all !== 48'h0) $display("FAIL midreset_a: got %h expected 0", a_all);
    else passed++;
    checks++;
    if (b_all !== 48'h0) $display("FAIL midreset_b: got %h expected 0", b_all);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    w0 = a_wn; f0 = a_fdn; e0 = a_errn;
    data = 1'b0;
    send_bits(24'h3C3C3C, 14);
    idle_low(30);
    send_bits(24'h777777, 24);
    idle_low(int'(T_RESET_CYC));
    chk("midreset_ignored_writes", 32'(a_wn - w0), 32'd0);
    chk("midreset_ignored_fd", 32'(a_fdn - f0), 32'd0);
    chk("midreset_ignored_err", 32'(a_errn - e0), 32'd0);
    send_bits(24'h5A5A5A, 24);
    idle_low(int'(T_RESET_CYC));
    chk("midreset_writes", 32'(a_wn - w0), 32'd1);
    chk("midreset_grb", 32'(a_wd[w0 % 64]), 32'h5A5A5A);
    chk("midreset_fd", 32'(a_fdn - f0), 32'd1);
    chk("midreset_count", 32'(a_fcnt), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    data   = 1'b0;
    pt_win = 1'b0;
    test_reset();
    test_single_pixel();
    test_glitch();
    test_partial();
    test_long_pulse();
    test_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decoder for the WS2812 single-wire LED protocol: samples an incoming strip data line and measures each high pulse to classify it as a 0 or 1 symbol.
- Assembles 24-bit GRB pixels, MSB first, and writes each completed pixel to an external pixel RAM through a one-cycle write strobe.
- Signals end of frame when it detects the >50 us low reset gap.
- Used for loopback test of the strip driver and for capturing upstream controller frames in the cape FPGA.

Parameters:
- LED_COUNT, 256: pixels accepted per frame; address range 0..LED_COUNT-1; legal 1..512.
- REVERSE, 0: nonzero maps pixel index n to address LED_COUNT-1-n.
- CYCLES_MIN_HIGH, 8: high pulses shorter than this are glitches (0.16 us @ 50MHz).
- CYCLES_THRESHOLD, 32: high length >= this decodes as 1, otherwise 0 (0.64 us).
- CYCLES_MAX_HIGH, 60: high length > this is an error (1.2 us).
- CYCLES_RESET, 2500: low length that ends a frame (50 us).

Ports:
- clk_i  in  1  system clock, 50 MHz.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  1  WS2812 line, asynchronous to clk_i.
- address_o  out  9  pixel RAM write address.
- r_o  out  8  red byte.
- g_o  out  8  green byte.
- b_o  out  8  blue byte.
- we_o  out  1  one-cycle write strobe; address and colour outputs are valid while it is high.
- frame_done_o  out  1  one-cycle pulse at end of frame.
- pixel_count_o  out  10  pixels received in the last frame, saturating at 1023; updated with frame_done_o.
- overflow_o  out  1  last frame carried more than LED_COUNT pixels; updated with frame_done_o.
- error_o  out  1  one-cycle pulse on any protocol error.
- data_o  out  1  pass-through; see Optional Feature.

Behaviour:
- Reset: every output is 0, and the FSM enters SYNC.
- Reset is asynchronous. Asserting it mid-frame discards the partial pixel, and no write completes.
- data_i passes through a 2-flop synchronizer to give din_s, adding 2 cycles of latency.
- Edges are detected against a one-cycle-delayed copy of din_s.
- high_cnt (12 bits, saturating) clears on a rising edge and increments while din_s=1. Its value at the falling edge is the high length H.
- low_cnt (12 bits, saturating) clears on a falling edge and increments while din_s=0.
- gap is asserted for exactly one cycle, when low_cnt reaches CYCLES_RESET-1 while din_s=0.
- FSM states:
  - SYNC: ignore edges. On gap -> IDLE.
  - IDLE: clear bit_idx=23, pix_idx=0, ovf=0. On a rising edge -> DATA.
  - DATA: on each falling edge, classify H:
    - H < CYCLES_MIN_HIGH or H > CYCLES_MAX_HIGH: pulse error_o and go to SYNC. No frame_done_o and no write for the partial pixel; already-written pixels remain.
    - Otherwise shift the bit into shift[bit_idx], with bit = (H >= CYCLES_THRESHOLD).
    - If bit_idx == 0: the pixel is complete; reload bit_idx=23.
    - Otherwise decrement bit_idx.
  - DATA on gap:
    - Pulse frame_done_o, load pixel_count_o=pix_idx and overflow_o=ovf, then go to IDLE.
    - If bit_idx != 23 (partial pixel), also pulse error_o in the same cycle; the partial pixel is dropped.
- Pixel write: on the cycle after the 24th bit:
  - If pix_idx < LED_COUNT: we_o=1, with g_o=shift[23:16], r_o=shift[15:8], b_o=shift[7:0] and address_o mapped per REVERSE.
  - Otherwise no write; set ovf.
  - In both cases pix_idx increments, saturating at 1023.
- The write and a subsequent gap cannot coincide, because gap needs at least 2500 cycles after a falling edge.
- Address and colour outputs hold their values between writes.
- Because of the synchronizer, H equals the input high time in cycles, ±1.

Optional Feature:
- WS2812_RX_PASSTHRU_EN defined:
  - data_o = din_s while in DATA and pix_idx >= LED_COUNT, i.e. excess pixels are forwarded to a downstream strip.
  - data_o = 0 otherwise.
  - The forwarded data is registered, giving 3 cycles of latency from data_i.
- WS2812_RX_PASSTHRU_EN not defined: data_o is tied to 0.
- overflow_o reporting is identical in both builds.

Decomposition:
- Package ws2812_pkg holds:
  - the state enum (SYNC, IDLE, DATA);
  - the 50 MHz timing constants shared with the strip driver (bit period 63, 0-high 21, 1-high 42, reset 2600);
  - the GRB packing order;
  - the pixel field widths.
- One sub-module, ws2812_pulse_meter, contains the synchronizer, edge detect, high_cnt/low_cnt and gap. It outputs fall_strobe, high_len and gap.

Test Plan:
- Low for 2600 cycles, then one pixel (0-high 21 cycles, 1-high 42, bit period 63) with G=0xA5 R=0x3C B=0x0F, then low for 2600 cycles -> one we_o with address_o=0, g_o=A5, r_o=3C, b_o=0F. Then frame_done_o with pixel_count_o=1, overflow_o=0 and no error_o.
- LED_COUNT=4, REVERSE=1, 5 pixels followed by a gap -> four writes at addresses 3,2,1,0, then pixel_count_o=5 and overflow_o=1. With WS2812_RX_PASSTHRU_EN, data_o replays the 5th pixel's pulses delayed by 3 cycles.
- Gap, then a 4-cycle high pulse -> error_o, no write. The FSM stays in SYNC until 2500 low cycles, then receives a valid pixel normally.
- Gap, then 12 valid bits, then a gap -> no write, with error_o and frame_done_o in the same cycle and pixel_count_o=0.
- A high pulse of 70 cycles inside a pixel -> error_o and no frame_done_o on the following gap. The next frame is decoded after the second gap.
- Assert rst_ni mid-pixel for 1 cycle -> all outputs 0 immediately. Edges arriving before a 2500-cycle low are ignored.
